// File: rtl/boot_loader_ctrl_pkg.sv
// Shared types and constants for the boot loader controller and its word packer.
package boot_pkg;

  typedef enum logic [2:0] {
    S_SEND_READY = 3'd0,
    S_TX_GUARD   = 3'd1,
    S_RECV_SIZE  = 3'd2,
    S_RECV_PROG  = 3'd3,
    S_SEND_DONE  = 3'd4,
    S_RUN        = 3'd5,
    S_ERROR      = 3'd6
  } boot_state_t;

  localparam logic [7:0] READY_BYTE_DEF = 8'h99;
  localparam logic [7:0] DONE_BYTE_DEF  = 8'hAA;

  typedef logic [1:0] lane_t;
  localparam lane_t LAST_LANE = 2'd3;

  // Drop a byte into its little-endian lane of a 32-bit word.
  function automatic logic [31:0] place_byte(input logic [31:0] word, input lane_t lane,
                                             input logic [7:0] data);
    logic [31:0] w;
    w = word;
    w[{lane, 3'b000} +: 8] = data;
    return w;
  endfunction

endpackage

// File: rtl/boot_loader_ctrl_word_packer.sv
// Packs program bytes little-endian into 32-bit words and emits one write pulse
// per word; a short final word is flushed with its upper bytes zero.
module boot_word_packer
  import boot_pkg::*;
#(
  parameter int IMEM_ADDR_WIDTH = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  input  logic                       byte_last,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]                imem_wdata,
  output logic [IMEM_ADDR_WIDTH:0]   words_loaded
);

  lane_t       lane_r;
  logic [31:0] buf_r;
  logic [31:0] word_s;
  logic        flush_s;

  // Word being assembled including the incoming byte, and whether it completes a word.
  always_comb begin
    word_s  = place_byte(buf_r, lane_r, byte_data);
    flush_s = byte_valid && (byte_last || (lane_r == LAST_LANE));
  end

  // Byte shift-in and write pulse; a flushed word leaves a fresh buffer for the next byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_r       <= 2'd0;
      buf_r        <= 32'd0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= 32'd0;
      words_loaded <= '0;
    end else begin
      imem_we <= flush_s;
      if (flush_s) begin
        imem_wdata <= word_s;
        buf_r      <= 32'd0;
        lane_r     <= 2'd0;
      end else if (byte_valid) begin
        buf_r  <= word_s;
        lane_r <= lane_r + 2'd1;
      end else begin
        buf_r  <= buf_r;
        lane_r <= lane_r;
      end
      // The address advances only after the pulse that used it.
      if (imem_we) begin
        imem_waddr   <= imem_waddr + IMEM_ADDR_WIDTH'(1);
        words_loaded <= words_loaded + (IMEM_ADDR_WIDTH + 1)'(1);
      end else begin
        imem_waddr   <= imem_waddr;
        words_loaded <= words_loaded;
      end
    end
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// UART boot sequencer: announce, receive length and program, load IMEM, release the core.
// Define BOOT_CHECKSUM_EN to send an 8-bit program byte sum before the done byte.
module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter int         IMEM_ADDR_WIDTH = 14,
  parameter logic [7:0] READY_BYTE      = READY_BYTE_DEF,
  parameter logic [7:0] DONE_BYTE       = DONE_BYTE_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       rx_ferr,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]                imem_wdata,
  output logic                       cpu_run,
  output logic                       boot_error,
  output logic [IMEM_ADDR_WIDTH:0]   words_loaded
);

  localparam logic [32:0] CAPACITY = 33'd4 << IMEM_ADDR_WIDTH;

  boot_state_t state_r;
  boot_state_t ret_r;
  logic        guard_r;
  logic [1:0]  size_cnt_r;
  logic [23:0] size_r;
  logic [31:0] remaining_r;
  logic [31:0] size_full_s;
  logic        prog_byte_s;
  logic        prog_last_s;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  csum_r;
  logic        csum_sent_r;
`endif

  // Decode the incoming byte against the current state.
  always_comb begin
    size_full_s = {rx_data, size_r};
    prog_last_s = (remaining_r == 32'd1);
    if (state_r == S_RECV_PROG) begin
      prog_byte_s = rx_valid && !rx_ferr;
    end else begin
      prog_byte_s = 1'b0;
    end
  end

  // Boot sequencing FSM with registered UART and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_SEND_READY;
      ret_r       <= S_RECV_SIZE;
      guard_r     <= 1'b0;
      size_cnt_r  <= 2'd0;
      size_r      <= 24'd0;
      remaining_r <= 32'd0;
      tx_data     <= 8'd0;
      tx_start    <= 1'b0;
      cpu_run     <= 1'b0;
      boot_error  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_r      <= 8'd0;
      csum_sent_r <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      case (state_r)
        S_SEND_READY: begin
          if (!tx_busy) begin
            tx_data  <= READY_BYTE;
            tx_start <= 1'b1;
            guard_r  <= 1'b1;
            ret_r    <= S_RECV_SIZE;
            state_r  <= S_TX_GUARD;
          end
        end
        // The transmitter reports busy one cycle after the start pulse.
        S_TX_GUARD: begin
          if (guard_r) begin
            guard_r <= 1'b0;
          end else if (!tx_busy) begin
            state_r <= ret_r;
            cpu_run <= (ret_r == S_RUN);
          end
        end
        S_RECV_SIZE: begin
          if (rx_valid && rx_ferr) begin
            state_r    <= S_ERROR;
            boot_error <= 1'b1;
          end else if (rx_valid) begin
            size_cnt_r <= size_cnt_r + 2'd1;
            case (size_cnt_r)
              2'd0: size_r[7:0]   <= rx_data;
              2'd1: size_r[15:8]  <= rx_data;
              2'd2: size_r[23:16] <= rx_data;
              default: begin
                remaining_r <= size_full_s;
                if (size_full_s == 32'd0) begin
                  state_r <= S_SEND_DONE;
                end else if ({1'b0, size_full_s} > CAPACITY) begin
                  state_r    <= S_ERROR;
                  boot_error <= 1'b1;
                end else begin
                  state_r <= S_RECV_PROG;
                end
              end
            endcase
          end
        end
        // The final word write pulses on the first S_SEND_DONE cycle, ahead of any tx.
        S_RECV_PROG: begin
          if (rx_valid && rx_ferr) begin
            state_r    <= S_ERROR;
            boot_error <= 1'b1;
          end else if (rx_valid) begin
            remaining_r <= remaining_r - 32'd1;
`ifdef BOOT_CHECKSUM_EN
            csum_r <= csum_r + rx_data;
`endif
            if (prog_last_s) begin
              state_r <= S_SEND_DONE;
            end
          end
        end
        S_SEND_DONE: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            guard_r  <= 1'b1;
            state_r  <= S_TX_GUARD;
`ifdef BOOT_CHECKSUM_EN
            if (!csum_sent_r) begin
              tx_data     <= csum_r;
              csum_sent_r <= 1'b1;
              ret_r       <= S_SEND_DONE;
            end else begin
              tx_data <= DONE_BYTE;
              ret_r   <= S_RUN;
            end
`else
            tx_data <= DONE_BYTE;
            ret_r   <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          cpu_run <= 1'b1;
        end
        S_ERROR: begin
          cpu_run    <= 1'b0;
          boot_error <= 1'b1;
        end
        default: begin
          state_r    <= S_ERROR;
          cpu_run    <= 1'b0;
          boot_error <= 1'b1;
        end
      endcase
    end
  end

  boot_word_packer #(
    .IMEM_ADDR_WIDTH(IMEM_ADDR_WIDTH)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .byte_valid  (prog_byte_s),
    .byte_data   (rx_data),
    .byte_last   (prog_last_s),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .words_loaded(words_loaded)
  );

endmodule
